// File: rtl/fetch_issue_queue.sv
// rtl/fetch_issue_queue.sv - two-in/two-out circular instruction queue between fetch and decode
module fetch_issue_queue #(
  parameter int ENTRY_W = 66,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               fetch_valid,
  input  logic [ENTRY_W-1:0] buffIn_D1,
  input  logic [ENTRY_W-1:0] buffIn_D2,
  input  logic               dec_ready_1,
  input  logic               dec_ready_2,
  output logic               stall_F,
  output logic               out_valid_1,
  output logic               out_valid_2,
  output logic [ENTRY_W-1:0] out_D1,
  output logic [ENTRY_W-1:0] out_D2,
  output logic [CNT_W-1:0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head, tail, head_nx, tail_nx;
  logic [CNT_W-1:0]   count;
  logic               push_en, slot1_taken, pop1, pop2;
  logic [1:0]         push_cnt, pop_cnt;

  // Stall looks only at registered count so dec_ready never reaches fetch combinationally.
  assign stall_F     = (count > CNT_W'(DEPTH - 2));
  assign push_en     = fetch_valid & ~stall_F & ~flush;
  assign slot1_taken = buffIn_D1[ENTRY_W-1] & buffIn_D1[ENTRY_W-2];
  assign push_cnt    = !push_en ? 2'd0 : (slot1_taken ? 2'd1 : 2'd2);

  assign head_nx = head + PTR_W'(1);
  assign tail_nx = tail + PTR_W'(1);

  assign out_valid_1 = (count >= CNT_W'(1));
  assign out_valid_2 = (count >= CNT_W'(2));
  assign out_D1      = out_valid_1 ? mem[head]    : '0;
  assign out_D2      = out_valid_2 ? mem[head_nx] : '0;
  assign occupancy   = count;

  assign pop1    = out_valid_1 & dec_ready_1;
  assign pop2    = pop1 & out_valid_2 & dec_ready_2;
  assign pop_cnt = {1'b0, pop1} + {1'b0, pop2};

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_cnt);
      tail  <= tail + PTR_W'(push_cnt);
      count <= count + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
    end
  end

  // Storage needs no reset; visibility is governed by count.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[tail] <= buffIn_D1;
      if (push_cnt == 2'd2) mem[tail_nx] <= buffIn_D2;
    end
  end

endmodule

// File: tb/tb_fetch_issue_queue.sv
// tb/tb_fetch_issue_queue.sv - directed table, wrap sequence and randomized model check of fetch_issue_queue
module tb_fetch_issue_queue;

  localparam int ENTRY_W = 66;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               reset, flush, fetch_valid, dec_ready_1, dec_ready_2;
  logic [ENTRY_W-1:0] buffIn_D1, buffIn_D2;
  logic               stall_F, out_valid_1, out_valid_2;
  logic [ENTRY_W-1:0] out_D1, out_D2;
  logic [CNT_W-1:0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ENTRY_W-1:0] mq[$];

  typedef struct {
    bit          rst, fl, fv, tk, r1, r2;
    logic [31:0] pc;
    int          occ;
    bit          stl;
    logic [31:0] pc1, pc2;
  } vec_t;

  vec_t tbl[22];

  fetch_issue_queue #(.ENTRY_W(ENTRY_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .fetch_valid(fetch_valid),
    .buffIn_D1(buffIn_D1), .buffIn_D2(buffIn_D2),
    .dec_ready_1(dec_ready_1), .dec_ready_2(dec_ready_2),
    .stall_F(stall_F), .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .out_D1(out_D1), .out_D2(out_D2), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] pkt(bit hit, bit pbj, logic [31:0] pc);
    return {hit, pbj, pc, pc ^ 32'hA5A5_0F0F};
  endfunction

  function automatic vec_t mk(bit rst, bit fl, bit fv, bit tk, logic [31:0] pc, bit r1, bit r2,
                              int occ, bit stl, logic [31:0] pc1, logic [31:0] pc2);
    vec_t v;
    v.rst = rst; v.fl = fl; v.fv = fv; v.tk = tk; v.pc = pc; v.r1 = r1; v.r2 = r2;
    v.occ = occ; v.stl = stl; v.pc1 = pc1; v.pc2 = pc2;
    return v;
  endfunction

  task automatic chk(string name, logic [65:0] act, logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a FIFO of packets; each cycle pop the front, then append accepted fetch packets.
  task automatic model_update(bit rst, bit fl, bit fv, logic [65:0] d1, logic [65:0] d2, bit r1, bit r2);
    bit full;
    int pops;
    full = (DEPTH - mq.size()) < 2;
    if (!rst || fl) begin
      mq.delete();
    end else begin
      pops = 0;
      if (r1 && mq.size() >= 1) pops = (r2 && mq.size() >= 2) ? 2 : 1;
      repeat (pops) void'(mq.pop_front());
      if (fv && !full) begin
        mq.push_back(d1);
        if (!(d1[65] && d1[64])) mq.push_back(d2);
      end
    end
  endtask

  task automatic model_compare();
    int n;
    n = mq.size();
    chk("occupancy", 66'(occupancy), 66'(n));
    chk("stall_F", 66'(stall_F), 66'((DEPTH - n) < 2));
    chk("out_valid_1", 66'(out_valid_1), 66'(n >= 1));
    chk("out_valid_2", 66'(out_valid_2), 66'(n >= 2));
    chk("out_D1", out_D1, (n >= 1) ? mq[0] : 66'd0);
    chk("out_D2", out_D2, (n >= 2) ? mq[1] : 66'd0);
  endtask

  task automatic step(bit rst, bit fl, bit fv, logic [65:0] d1, logic [65:0] d2, bit r1, bit r2);
    reset = rst; flush = fl; fetch_valid = fv; buffIn_D1 = d1; buffIn_D2 = d2;
    dec_ready_1 = r1; dec_ready_2 = r2;
    model_update(rst, fl, fv, d1, d2, r1, r2);
    @(posedge clk);
    @(negedge clk);
    model_compare();
  endtask

  initial begin
    logic [31:0] next_pc, pop_pc;
    reset = 1'b0; flush = 1'b0; fetch_valid = 1'b0; dec_ready_1 = 1'b0; dec_ready_2 = 1'b0;
    buffIn_D1 = '0; buffIn_D2 = '0;

    //            rst fl fv tk pc          r1 r2 occ stl pc1         pc2
    tbl[0]  = mk(0, 0, 0, 0, 32'h00, 0, 0, 0, 0, 32'h00, 32'h00);
    tbl[1]  = mk(0, 0, 0, 0, 32'h00, 0, 0, 0, 0, 32'h00, 32'h00);
    tbl[2]  = mk(1, 0, 1, 0, 32'h00, 0, 0, 2, 0, 32'h00, 32'h04);
    tbl[3]  = mk(1, 0, 1, 0, 32'h08, 0, 0, 4, 0, 32'h00, 32'h04);
    tbl[4]  = mk(1, 0, 1, 0, 32'h10, 0, 0, 6, 0, 32'h00, 32'h04);
    tbl[5]  = mk(1, 0, 1, 0, 32'h18, 0, 0, 8, 1, 32'h00, 32'h04);
    tbl[6]  = mk(1, 0, 1, 0, 32'h20, 0, 0, 8, 1, 32'h00, 32'h04);
    tbl[7]  = mk(1, 0, 0, 0, 32'h00, 1, 1, 6, 0, 32'h08, 32'h0C);
    tbl[8]  = mk(1, 0, 0, 0, 32'h00, 1, 1, 4, 0, 32'h10, 32'h14);
    tbl[9]  = mk(1, 0, 0, 0, 32'h00, 0, 1, 4, 0, 32'h10, 32'h14);
    tbl[10] = mk(1, 0, 0, 0, 32'h00, 1, 0, 3, 0, 32'h14, 32'h18);
    tbl[11] = mk(1, 0, 1, 1, 32'h40, 0, 0, 4, 0, 32'h14, 32'h18);
    tbl[12] = mk(1, 0, 0, 0, 32'h00, 1, 1, 2, 0, 32'h1C, 32'h40);
    tbl[13] = mk(1, 0, 1, 0, 32'h80, 1, 0, 3, 0, 32'h40, 32'h80);
    tbl[14] = mk(1, 0, 1, 1, 32'h90, 0, 0, 4, 0, 32'h40, 32'h80);
    tbl[15] = mk(1, 0, 1, 0, 32'h98, 0, 0, 6, 0, 32'h40, 32'h80);
    tbl[16] = mk(1, 1, 1, 0, 32'hA0, 1, 0, 0, 0, 32'h00, 32'h00);
    tbl[17] = mk(1, 0, 1, 0, 32'hB0, 0, 0, 2, 0, 32'hB0, 32'hB4);
    tbl[18] = mk(1, 0, 1, 0, 32'hC0, 0, 0, 4, 0, 32'hB0, 32'hB4);
    tbl[19] = mk(1, 0, 1, 0, 32'hD0, 0, 0, 6, 0, 32'hB0, 32'hB4);
    tbl[20] = mk(1, 0, 1, 1, 32'hE0, 0, 0, 7, 1, 32'hB0, 32'hB4);
    tbl[21] = mk(0, 1, 1, 0, 32'hF0, 1, 1, 0, 0, 32'h00, 32'h00);

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst, tbl[i].fl, tbl[i].fv, pkt(tbl[i].tk, tbl[i].tk, tbl[i].pc),
           pkt(0, 0, tbl[i].pc + 32'd4), tbl[i].r1, tbl[i].r2);
      chk($sformatf("tbl%0d_occ", i), 66'(occupancy), 66'(tbl[i].occ));
      chk($sformatf("tbl%0d_stall", i), 66'(stall_F), 66'(tbl[i].stl));
      if (tbl[i].occ >= 1) chk($sformatf("tbl%0d_pc1", i), 66'(out_D1[63:32]), 66'(tbl[i].pc1));
      else                 chk($sformatf("tbl%0d_d1", i), out_D1, 66'd0);
      if (tbl[i].occ >= 2) chk($sformatf("tbl%0d_pc2", i), 66'(out_D2[63:32]), 66'(tbl[i].pc2));
      else                 chk($sformatf("tbl%0d_d2", i), out_D2, 66'd0);
    end

    // Normal pushes resume after reset.
    step(1, 0, 1, pkt(0, 0, 32'hF0), pkt(0, 0, 32'hF4), 0, 0);
    chk("post_reset_occ", 66'(occupancy), 66'd2);
    chk("post_reset_pc1", 66'(out_D1[63:32]), 66'h0F0);

    // Steady state at 6 entries with 2-in/2-out across many pointer wraps.
    step(0, 0, 0, '0, '0, 0, 0);
    next_pc = 32'h1000;
    pop_pc  = 32'h1000;
    repeat (3) begin
      step(1, 0, 1, pkt(0, 0, next_pc), pkt(0, 0, next_pc + 4), 0, 0);
      next_pc += 8;
    end
    chk("steady_fill", 66'(occupancy), 66'd6);
    for (int c = 0; c < 20; c++) begin
      chk("steady_pop_pc1", 66'(out_D1[63:32]), 66'(pop_pc));
      chk("steady_pop_pc2", 66'(out_D2[63:32]), 66'(pop_pc + 32'd4));
      pop_pc += 8;
      step(1, 0, 1, pkt(0, 0, next_pc), pkt(0, 0, next_pc + 4), 1, 1);
      next_pc += 8;
      chk("steady_occ", 66'(occupancy), 66'd6);
    end

    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pc;
      bit tk;
      pc = $urandom() & 32'hFFFF_FFFC;
      tk = ($urandom_range(3) == 0);
      step(($urandom_range(199) != 0), ($urandom_range(49) == 0), ($urandom_range(3) != 0),
           pkt(tk | ($urandom_range(1) == 1), tk, pc), pkt($urandom_range(1) == 1, 0, pc + 4),
           $urandom_range(1) == 1, $urandom_range(2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
